// File: rtl/rtype_pkg.sv
// rtype_pkg: funct encodings, ALU op enum and the funct decoder shared by
// the R-type execute pipe and its ALU.
package rtype_pkg;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  typedef enum logic [3:0] {
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU
  } op_e;

  typedef struct packed {
    op_e  op;
    logic illegal;
  } dec_t;

  // Unknown functs decode as ADD with illegal set; the pipe zeroes the result.
  function automatic dec_t decode(input logic [5:0] f);
    dec_t d;
    d.op      = OP_ADD;
    d.illegal = 1'b0;
    case (f)
      F_SLL:   d.op = OP_SLL;
      F_SRL:   d.op = OP_SRL;
      F_SRA:   d.op = OP_SRA;
      F_SLLV:  d.op = OP_SLLV;
      F_SRLV:  d.op = OP_SRLV;
      F_SRAV:  d.op = OP_SRAV;
      F_ADD:   d.op = OP_ADD;
      F_ADDU:  d.op = OP_ADDU;
      F_SUB:   d.op = OP_SUB;
      F_SUBU:  d.op = OP_SUBU;
      F_AND:   d.op = OP_AND;
      F_OR:    d.op = OP_OR;
      F_XOR:   d.op = OP_XOR;
      F_NOR:   d.op = OP_NOR;
      F_SLT:   d.op = OP_SLT;
      F_SLTU:  d.op = OP_SLTU;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rtype_alu.sv
// rtype_alu: combinational R-type ALU. a = rs operand, b = rt operand.
// Shifts act on b; variable shifts take the amount from the low bits of a.
// ovf flags signed overflow of ADD/SUB only.
module rtype_alu
  import rtype_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [SHW-1:0]  shamt,
  input  op_e             op,
  output logic [XLEN-1:0] y,
  output logic            ovf
);

  logic [XLEN-1:0] sum, dif;
  assign sum = a + b;
  assign dif = a - b;

  // Operation select and signed-overflow detect
  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_SLL:  y = b << shamt;
      OP_SRL:  y = b >> shamt;
      OP_SRA:  y = $signed(b) >>> shamt;
      OP_SLLV: y = b << a[SHW-1:0];
      OP_SRLV: y = b >> a[SHW-1:0];
      OP_SRAV: y = $signed(b) >>> a[SHW-1:0];
      OP_ADD: begin
        y   = sum;
        ovf = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      OP_ADDU: y = sum;
      OP_SUB: begin
        y   = dif;
        ovf = (a[XLEN-1] != b[XLEN-1]) && (dif[XLEN-1] != a[XLEN-1]);
      end
      OP_SUBU: y = dif;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rtype_exec_pipe.sv
// rtype_exec_pipe: 2-stage valid/ready R-type execute pipe with its own
// register file. Stage 1 reads operands (bypass from stage 2, preload port)
// and computes; stage 2 holds the result until res_ready, then writes back.
// Optional: define ALU_OVF_TRAP_EN to trap signed overflow on add/sub
// (res_ovf set, no writeback, no forwarding).
module rtype_exec_pipe
  import rtype_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int NREGS     = 32,
  parameter  int REG0_ZERO = 1,
  localparam int AW        = $clog2(NREGS),
  localparam int SHW       = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   rs,
  input  logic [AW-1:0]   rt,
  input  logic [AW-1:0]   rd,
  input  logic [SHW-1:0]  shamt,
  input  logic [5:0]      funct,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic [AW-1:0]   res_rd,
  output logic            res_err,
  output logic            res_ovf,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

`ifdef ALU_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [NREGS-1:0][XLEN-1:0] rf;
  logic [1:0][AW-1:0]         ridx;
  logic [1:0][XLEN-1:0]       opnd;
  logic [XLEN-1:0]            alu_y;
  logic                       alu_ovf, ovf_eff, wb_ok, accept;
  dec_t                       dec;

  // A held result is writeable (and thus forwardable) unless errored,
  // trapped, or aimed at a hardwired-zero r0.
  assign wb_ok    = !res_err && !res_ovf && !((REG0_ZERO != 0) && (res_rd == '0));
  assign in_ready = !res_valid || res_ready;
  assign accept   = in_valid && in_ready;
  assign dec      = decode(funct);
  assign ovf_eff  = TRAP_EN && alu_ovf && !dec.illegal;
  assign dbg_data = ((REG0_ZERO != 0) && (dbg_addr == '0)) ? '0 : rf[dbg_addr];

  // Operand read: regfile, overridden by same-cycle preload, overridden by
  // stage-2 bypass (matches writeback-wins at the edge); r0 forced to zero.
  always_comb begin
    ridx[0] = rs;
    ridx[1] = rt;
    opnd    = '0;
    for (int p = 0; p < 2; p++) begin
      opnd[p] = rf[ridx[p]];
      if (ld_en && (ld_addr == ridx[p]))
        opnd[p] = ld_data;
      if (res_valid && wb_ok && (res_rd == ridx[p]))
        opnd[p] = res_data;
      if ((REG0_ZERO != 0) && (ridx[p] == '0))
        opnd[p] = '0;
    end
  end

  rtype_alu #(.XLEN(XLEN)) u_alu (
    .a     (opnd[0]),
    .b     (opnd[1]),
    .shamt (shamt),
    .op    (dec.op),
    .y     (alu_y),
    .ovf   (alu_ovf)
  );

  // Stage-2 result register with valid/ready hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_err   <= 1'b0;
      res_ovf   <= 1'b0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_data  <= dec.illegal ? '0 : alu_y;
      res_rd    <= rd;
      res_err   <= dec.illegal;
      res_ovf   <= ovf_eff;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Register file: preload port, then writeback (writeback wins on collision)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf <= '0;
    end else begin
      if (ld_en && !((REG0_ZERO != 0) && (ld_addr == '0)))
        rf[ld_addr] <= ld_data;
      if (res_valid && res_ready && wb_ok)
        rf[res_rd] <= res_data;
    end
  end

endmodule

// File: tb/tb_rtype_exec_pipe.sv
// tb_rtype_exec_pipe: table-driven vector check of every funct plus
// hand-written sequences for bypass, stall, r0, preload and mid-op reset.
module tb_rtype_exec_pipe;
  import rtype_pkg::*;

`ifdef ALU_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic        res_valid, res_ready = 1'b1;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_err, res_ovf;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0, dbg_addr = '0;
  logic [31:0] ld_data = '0, dbg_data;

  int nchk = 0, nerr = 0;

  rtype_exec_pipe #(.XLEN(32), .NREGS(32), .REG0_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_err(res_err), .res_ovf(res_ovf),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [31:0] exp;
    logic        err, ovf;
    logic [31:0] wb;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic dbg(input string nm, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1 chk(nm, dbg_data, exp);
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic drive(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [4:0] sh, input logic [5:0] fn);
    rs = s; rt = t; rd = d; shamt = sh; funct = fn; in_valid = 1'b1;
  endtask

  function automatic vec_t mk(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                              input logic [4:0] sh, input logic [5:0] fn, input logic [31:0] e,
                              input logic er, input logic ov, input logic [31:0] w);
    vec_t v;
    v.rs = s; v.rt = t; v.rd = d; v.sh = sh; v.fn = fn;
    v.exp = e; v.err = er; v.ovf = ov; v.wb = w;
    return v;
  endfunction

  initial begin
    // r1=1 r2=2 r5=0x80000000 r6=-1 r7=33 r8=0x7FFFFFFF
    vt[0]  = mk(1, 2,  9, 0, F_ADD,  32'h3,        0, 0, 32'h3);
    vt[1]  = mk(1, 2, 10, 0, F_ADDU, 32'h3,        0, 0, 32'h3);
    vt[2]  = mk(1, 2, 11, 0, F_SUB,  32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF);
    vt[3]  = mk(2, 1, 12, 0, F_SUBU, 32'h1,        0, 0, 32'h1);
    vt[4]  = mk(5, 6, 13, 0, F_AND,  32'h80000000, 0, 0, 32'h80000000);
    vt[5]  = mk(1, 2, 14, 0, F_OR,   32'h3,        0, 0, 32'h3);
    vt[6]  = mk(6, 1, 15, 0, F_XOR,  32'hFFFFFFFE, 0, 0, 32'hFFFFFFFE);
    vt[7]  = mk(1, 2, 16, 0, F_NOR,  32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC);
    vt[8]  = mk(0, 5, 17, 2, F_SRL,  32'h20000000, 0, 0, 32'h20000000);
    vt[9]  = mk(0, 5, 18, 2, F_SRA,  32'hE0000000, 0, 0, 32'hE0000000);
    vt[10] = mk(0, 1, 19, 31, F_SLL, 32'h80000000, 0, 0, 32'h80000000);
    vt[11] = mk(7, 5, 20, 0, F_SRAV, 32'hC0000000, 0, 0, 32'hC0000000);
    vt[12] = mk(7, 5, 21, 0, F_SRLV, 32'h40000000, 0, 0, 32'h40000000);
    vt[13] = mk(2, 1, 22, 0, F_SLLV, 32'h4,        0, 0, 32'h4);
    vt[14] = mk(6, 1, 23, 0, F_SLT,  32'h1,        0, 0, 32'h1);
    vt[15] = mk(6, 1, 24, 0, F_SLTU, 32'h0,        0, 0, 32'h0);
    vt[16] = mk(1, 6, 25, 0, F_SLT,  32'h0,        0, 0, 32'h0);
    vt[17] = mk(1, 2, 26, 0, 6'b111111, 32'h0,     1, 0, 32'h0);
    vt[18] = mk(8, 1, 27, 0, F_ADD,  32'h80000000, 0, TRAP, TRAP ? 32'h0 : 32'h80000000);

    // Reset state
    #1;
    chk("rst res_valid", res_valid, 0);
    chk("rst res_data", res_data, 0);
    chk("rst res_err", res_err, 0);
    chk("rst res_ovf", res_ovf, 0);
    chk("rst in_ready", in_ready, 1);
    dbg("rst dbg r5", 5, 0);
    @(negedge clk); rst_n = 1'b1;

    preload(1, 32'h1);
    preload(2, 32'h2);
    preload(5, 32'h80000000);
    preload(6, 32'hFFFFFFFF);
    preload(7, 32'd33);
    preload(8, 32'h7FFFFFFF);
    dbg("preload r5", 5, 32'h80000000);

    // Vector table: one op at a time, checked result then writeback
    foreach (vt[i]) begin
      @(negedge clk);
      res_ready = 1'b1;
      drive(vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh, vt[i].fn);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d valid", i), res_valid, 1);
      chk($sformatf("v%0d data", i), res_data, vt[i].exp);
      chk($sformatf("v%0d err", i), res_err, vt[i].err);
      chk($sformatf("v%0d ovf", i), res_ovf, vt[i].ovf);
      chk($sformatf("v%0d rd", i), res_rd, vt[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d drained", i), res_valid, 0);
      dbg($sformatf("v%0d wb", i), vt[i].rd, vt[i].wb);
    end

    // Back-to-back dependent: r3 = r1+r2, then r4 = r3-r1 via bypass
    @(negedge clk);
    drive(1, 2, 3, 0, F_ADD);
    @(negedge clk);
    chk("b2b first", res_data, 3);
    chk("b2b in_ready", in_ready, 1);
    drive(3, 1, 4, 0, F_SUB);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b bypass", res_data, 2);
    chk("b2b rd", res_rd, 4);
    @(negedge clk);
    dbg("b2b r3", 3, 3);
    dbg("b2b r4", 4, 2);

    // Stall: hold res_ready low 3 cycles, then release for one writeback
    @(negedge clk);
    res_ready = 1'b0;
    drive(2, 2, 3, 0, F_ADD);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d in_ready", c), in_ready, 0);
      chk($sformatf("stall%0d valid", c), res_valid, 1);
      chk($sformatf("stall%0d data", c), res_data, 4);
      chk($sformatf("stall%0d rd", c), res_rd, 3);
      dbg($sformatf("stall%0d r3", c), 3, 3);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("release valid", res_valid, 0);
    dbg("release r3", 3, 4);

    // r0: preload and write are dropped; result aimed at r0 is not forwarded
    preload(0, 32'h5);
    dbg("r0 preload", 0, 0);
    @(negedge clk);
    drive(1, 2, 0, 0, F_ADD);
    @(negedge clk);
    chk("r0 result", res_data, 3);
    drive(0, 1, 29, 0, F_ADD);
    @(negedge clk);
    in_valid = 1'b0;
    chk("r0 no bypass", res_data, 1);
    @(negedge clk);
    dbg("r0 after wb", 0, 0);
    dbg("r29", 29, 1);

    // Same-cycle preload forwarding, then preload vs writeback collision
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 28; ld_data = 32'd10;
    drive(28, 1, 30, 0, F_ADD);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ld fwd", res_data, 11);
    ld_addr = 30; ld_data = 32'd99;
    @(negedge clk);
    ld_en = 1'b0;
    dbg("wb beats ld", 30, 11);

    // Reset while a result is held
    @(negedge clk);
    res_ready = 1'b0;
    drive(1, 2, 31, 0, F_ADD);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-rst valid", res_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst valid", res_valid, 0);
    chk("midrst data", res_data, 0);
    chk("midrst rd", res_rd, 0);
    chk("midrst err", res_err, 0);
    chk("midrst ovf", res_ovf, 0);
    dbg("midrst r1", 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("post-rst valid", res_valid, 0);
    dbg("post-rst r31", 31, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/rtype_exec_pipe.md
Name: rtype_exec_pipe

Overview:
- Parametrised successor to the flat R-type ALU: owns its register file and executes MIPS R-type ops in a 2-stage valid/ready pipeline.
- Stage 1 reads operands (with bypass) and computes; stage 2 holds the result until the consumer accepts it, then writes it back.
- Sits between the instruction decoder (upstream) and the writeback/trace consumer (downstream).

Parameters:
- XLEN, 32, data width (power of 2, ≥8)
- NREGS, 32, register count (power of 2); AW = $clog2(NREGS), SHW = $clog2(XLEN)
- REG0_ZERO, 1, when 1 r0 reads as 0 and writes to r0 are dropped

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- rs, rt, rd  in  AW each  source/destination register indices
- shamt  in  SHW  shift amount for fixed shifts
- funct  in  6  operation code
- res_valid  out  1  stage-2 result held
- res_ready  in  1  consumer accepts result
- res_data  out  XLEN  result
- res_rd  out  AW  destination index
- res_err  out  1  illegal funct; no writeback
- res_ovf  out  1  signed overflow trap (feature); otherwise tied 0
- ld_en, ld_addr[AW], ld_data[XLEN]  in  preload write port
- dbg_addr  in  AW; dbg_data  out  XLEN  combinational regfile read, no bypass

Behaviour:
- Reset: regfile all zeros; res_valid, res_data, res_rd, res_err, res_ovf = 0.
- Reset asserted mid-operation drops any held result without writeback.
- in_ready = !res_valid || res_ready (combinational).
- Accept at edge: stage 2 loads result, rd, err, ovf; res_valid = 1.
- Handshake at edge without a new accept: res_valid = 0.
- res_* stay stable while res_valid && !res_ready.
- Latency: result on res_* 1 cycle after acceptance.
- Writeback to the regfile happens on the edge where the res handshake completes, only if !res_err && !res_ovf and not (REG0_ZERO && rd == 0).
- Operand read: if res_valid && res_rd == rs && the held result is writeable (same rule as writeback), forward res_data. Same for rt. Otherwise read the regfile, then the preload value (see next item).
- Preload: ld_en writes ld_data at the edge. If ld_addr matches the index being read in the same cycle, the reader gets ld_data. If ld and writeback hit the same register, writeback wins.
- Operations (funct → result). Shifts always operate on rt. Variable shifts use rs[SHW-1:0].
  - sll 000000, srl 000010, sra 000011
  - sllv 000100, srlv 000110, srav 000111
  - add 100000, addu 100001, sub 100010, subu 100011 (modulo 2^XLEN)
  - and 100100, or 100101, xor 100110, nor 100111
  - slt 101010 (signed), sltu 101011 (unsigned); result zero-extended 0/1
- Any other funct: res_data = 0, res_err = 1.
- REG0_ZERO = 1: r0 reads as 0 from every path, including dbg and bypass.

Optional Feature:
- Macro ALU_OVF_TRAP_EN.
- Defined: add/sub with signed overflow set res_ovf = 1, keep the wrapped sum in res_data, suppress writeback, and are not forwarded. addu/subu never trap.
- Undefined: res_ovf is constant 0; add/sub wrap and write back.

Decomposition:
- Package rtype_pkg: funct localparams (F_ADD, F_SRL, …), an op enum, and a function mapping funct to {op, illegal}.
- One sub-module, rtype_alu: combinational; inputs a, b, shamt, op; outputs y and ovf; parametrised by XLEN.
- Regfile, bypass, and stage-2 register stay in the top module.

Test Plan:
- Preload r1 = 1, r2 = 2; add rs=1 rt=2 rd=3; res_ready = 1 → res_data = 3 one cycle later; dbg r3 = 3 the next cycle.
- Back-to-back dependent ops: add rd=3 = r1 + r2, then sub rd=4 = r3 − r1 → bypass gives r4 = 2.
- Hold res_ready = 0 for 3 cycles → in_ready = 0, res_* stable, r3 unchanged; release → one writeback only.
- srl rt=r5 (0x80000000), shamt 2 → 0x20000000. sra → 0xE0000000. srav with rs = 33 → shifts by 1.
- slt with r1 = −1, r2 = 1 → 1; sltu → 0. funct 111111 → res_err = 1, rd unchanged. Write to r0 leaves r0 = 0.
- With ALU_OVF_TRAP_EN: add 0x7FFFFFFF + 1 → res_ovf = 1, no writeback. Assert rst_n low while res_valid → all outputs 0 and regfile cleared.
